irq_responder_9: RTL and testbench
==================================

IRQ_RESPONDER_9 -- requirements
Module: irq_responder_9

Interface
REQ-001 The module SHALL have parameter BubblesMask, default 0, a 9-bit mask in which bit i set inverts Req[i] before edge detection.
REQ-002 The module SHALL have the port Clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have the port Reset_n, input, 1 bit, an asynchronous active-low reset.
REQ-004 The module SHALL have the port Req, input, 9 bits, raw request lines, channel i+1 on bit i.
REQ-005 The module SHALL have the port Enable, input, 9 bits, per-channel enable; a disabled channel still latches but is never granted.
REQ-006 The module SHALL have the port Ack, input, 1 bit, the servicer's acknowledge of the current grant.
REQ-007 The module SHALL have the port Irq, output, 1 bit, the OR of (Pending & Enable).
REQ-008 The module SHALL have the port Grant_Valid, output, 1 bit, high while a grant is outstanding.
REQ-009 The module SHALL have the port Grant_Id, output, 4 bits, the granted channel number 1..9, 0 when none.
REQ-010 The module SHALL have the port Pending, output, 9 bits, the latched request register.

Function
REQ-011 Effective request SHALL be eff[i] = Req[i] XOR BubblesMask[i]; the sampled copy req_q SHALL be registered every cycle.
REQ-012 At a clock edge where eff[i]=1 and req_q[i]=0, Pending[i] SHALL be set, visible after that edge.
REQ-013 The FSM SHALL have the states IDLE, GRANT and HOLDOFF.
REQ-014 In IDLE, if (Pending & Enable) is nonzero, the FSM SHALL register the selected channel into Grant_Id, set Grant_Valid and move to GRANT on the next edge; otherwise it SHALL stay in IDLE.
REQ-015 In GRANT, Grant_Valid and Grant_Id SHALL hold stable until Ack=1 is sampled; Enable changes SHALL NOT revoke the grant.
REQ-016 On Ack in GRANT, the FSM SHALL clear the granted Pending bit, drop Grant_Valid, set Grant_Id to 0 and move to HOLDOFF.
REQ-017 HOLDOFF SHALL last exactly one cycle, then return to IDLE, so that Ack has a one-cycle minimum gap.
REQ-018 Ack outside GRANT SHALL be ignored.
REQ-019 If a new edge on a channel coincides with the clear of that same channel, set SHALL win and Pending[i] SHALL remain 1.
REQ-020 Latency SHALL be Req high to Grant_Valid high in 2 cycles, provided the FSM is IDLE.
REQ-021 Irq SHALL be combinational from registers only, with no path from Req or Ack.

Reset
REQ-022 Reset_n low SHALL asynchronously force state to IDLE, Pending=0, Grant_Valid=0, Grant_Id=0 and Irq=0.
REQ-023 Reset SHALL force req_q to all ones, so that lines already high at reset release are not latched.
REQ-024 Reset asserted during GRANT SHALL discard the grant; no Ack is required afterwards.

Configuration
REQ-025 With IRQ_ROUND_ROBIN_EN defined, the module SHALL select the first enabled pending channel searching upward from (last granted + 1), wrapping 9 to 1; the pointer SHALL reset to 9 so the first search starts at 1, and SHALL update on Ack.
REQ-026 Without IRQ_ROUND_ROBIN_EN, the module SHALL use fixed priority, lowest channel number wins, with no pointer register.

Structure
REQ-027 A shared package irq_pkg SHALL hold the FSM state encoding, the constant NUM_CH=9 and the constant GRANT_NONE=4'd0.
REQ-028 The module SHALL use one sub-module, irq_prio_sel_9: a combinational 9-input selector taking the request vector and start index and returning a 4-bit id.

Verification
REQ-029 Scenario: Req[2] pulses high for 1 cycle, Enable=all ones -> Grant_Valid=1 and Grant_Id=3 two cycles later; Ack -> Pending=0 and Grant_Id=0.
REQ-030 Scenario: Req[0] and Req[4] rise together, round-robin build -> grants 1 then 5; Req[0] re-pulsed during grant 5 -> grant 1 after HOLDOFF.
REQ-031 Scenario: BubblesMask=9'h001 with Req[0] high through reset then falling -> no grant at release, Grant_Id=1 after the fall.
REQ-032 Scenario: Enable[3]=0 with Req[3] pulsed -> Pending[3]=1, Irq=0, no grant; Enable[3] set -> grant 4.
REQ-033 Scenario: Req[6] re-rises on the Ack cycle of grant 7 -> Pending[6] stays 1 and grant 7 is reissued after HOLDOFF.
REQ-034 Scenario: Reset_n pulsed low mid-GRANT -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the 9-channel interrupt responder: channel count,
// the "no grant" id, the FSM state encoding and the channel wrap helper.
package irq_pkg;

  localparam int          NUM_CH     = 9;
  localparam logic [3:0]  GRANT_NONE = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  // Channel numbers run 1..NUM_CH; the successor of the last channel is 1.
  function automatic logic [3:0] next_ch(input logic [3:0] ch);
    return (ch >= 4'(NUM_CH)) ? 4'd1 : ch + 4'd1;
  endfunction

endpackage

// File: rtl/irq_prio_sel_9.sv
// Combinational 9-input selector: first set request found searching upward
// from channel i_start (1..9, wrapping 9 to 1); returns GRANT_NONE if none.
module irq_prio_sel_9
  import irq_pkg::*;
(
  input  logic [NUM_CH-1:0] i_req,
  input  logic [3:0]        i_start,
  output logic [3:0]        o_id
);

  logic [3:0] w_ch;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    o_id = GRANT_NONE;
    w_ch = i_start;
    for (int k = 0; k < NUM_CH; k++) begin
      if ((o_id == GRANT_NONE) && i_req[w_ch - 4'd1]) o_id = w_ch;
      w_ch = next_ch(w_ch);
    end
  end

endmodule

// File: rtl/irq_responder_9.sv
// Edge-latched 9-channel interrupt responder with one outstanding grant at a time.
// Define IRQ_ROUND_ROBIN_EN for round-robin selection; default is fixed lowest-channel priority.
module irq_responder_9
  import irq_pkg::*;
#(
  parameter logic [NUM_CH-1:0] BubblesMask = '0
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [NUM_CH-1:0] Req,
  input  logic [NUM_CH-1:0] Enable,
  input  logic              Ack,
  output logic              Irq,
  output logic              Grant_Valid,
  output logic [3:0]        Grant_Id,
  output logic [NUM_CH-1:0] Pending
);

  logic [NUM_CH-1:0] r_req_q;
  logic [NUM_CH-1:0] r_pending;
  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_grant_valid;
  logic              w_grant_valid_nxt;
  logic [3:0]        r_grant_id;
  logic [3:0]        w_grant_id_nxt;
  logic [3:0]        w_sel_id;
  logic [3:0]        w_start;
  logic [NUM_CH-1:0] w_eff;
  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_cand;
  logic [NUM_CH-1:0] w_clr;
  logic              w_ack_grant;

  assign w_eff       = Req ^ BubblesMask;
  assign w_rise      = w_eff & ~r_req_q;
  assign w_cand      = r_pending & Enable;
  assign w_ack_grant = (r_state == ST_GRANT) && Ack;
  assign w_clr       = w_ack_grant ? (NUM_CH'(1) << (r_grant_id - 4'd1)) : '0;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [3:0] r_rr_ptr;

  // Pointer starts at the last channel so the first search begins at channel 1.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)         r_rr_ptr <= 4'(NUM_CH);
    else if (w_ack_grant) r_rr_ptr <= r_grant_id;
  end

  assign w_start = next_ch(r_rr_ptr);
`else
  assign w_start = 4'd1;
`endif

  irq_prio_sel_9 u_sel (
    .i_req   (w_cand),
    .i_start (w_start),
    .o_id    (w_sel_id)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_grant_valid_nxt = r_grant_valid;
    w_grant_id_nxt    = r_grant_id;
    case (r_state)
      ST_IDLE: begin
        if (|w_cand) begin
          w_state_nxt       = ST_GRANT;
          w_grant_valid_nxt = 1'b1;
          w_grant_id_nxt    = w_sel_id;
        end
      end
      ST_GRANT: begin
        if (Ack) begin
          w_state_nxt       = ST_HOLDOFF;
          w_grant_valid_nxt = 1'b0;
          w_grant_id_nxt    = GRANT_NONE;
        end
      end
      ST_HOLDOFF: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state       <= ST_IDLE;
      r_grant_valid <= 1'b0;
      r_grant_id    <= GRANT_NONE;
      r_pending     <= '0;
      // NOTE: req_q resets to ones so lines already high at release are not seen as edges.
      r_req_q       <= '1;
    end else begin
      r_state       <= w_state_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_grant_id    <= w_grant_id_nxt;
      r_pending     <= (r_pending & ~w_clr) | w_rise;
      r_req_q       <= w_eff;
    end
  end

  assign Irq         = |(r_pending & Enable);
  assign Grant_Valid = r_grant_valid;
  assign Grant_Id    = r_grant_id;
  assign Pending     = r_pending;

endmodule

// File: tb/tb_irq_responder_9.sv
// Self-checking bench for irq_responder_9: directed scenarios plus random traffic
// compared each cycle against a behavioural model of pending/grant rules.
module tb_irq_responder_9;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic [8:0] Req, Enable;
  logic       Ack;
  logic       Irq, Grant_Valid;
  logic [3:0] Grant_Id;
  logic [8:0] Pending;

  logic [8:0] Req_b;
  logic       Ack_b;
  logic       Irq_b, Grant_Valid_b;
  logic [3:0] Grant_Id_b;
  logic [8:0] Pending_b;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: previous effective inputs, pending set, granted channel
  // (0 = none), one-cycle gap flag and last serviced channel.
  logic [8:0] m_prev, m_pend;
  int         m_grant, m_last;
  bit         m_gap;

  always #5 Clock = ~Clock;

  irq_responder_9 #(.BubblesMask(9'h000)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Req(Req), .Enable(Enable), .Ack(Ack),
    .Irq(Irq), .Grant_Valid(Grant_Valid), .Grant_Id(Grant_Id), .Pending(Pending)
  );

  irq_responder_9 #(.BubblesMask(9'h001)) dut_b (
    .Clock(Clock), .Reset_n(Reset_n), .Req(Req_b), .Enable(Enable), .Ack(Ack_b),
    .Irq(Irq_b), .Grant_Valid(Grant_Valid_b), .Grant_Id(Grant_Id_b), .Pending(Pending_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [8:0] cand, input int last);
    for (int k = 0; k < 9; k++) begin
      int ch;
`ifdef IRQ_ROUND_ROBIN_EN
      ch = ((last + k) % 9) + 1;
`else
      ch = k + 1;
`endif
      if (cand[ch-1]) return ch;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_prev  = 9'h1ff;
    m_pend  = '0;
    m_grant = 0;
    m_gap   = 1'b0;
    m_last  = 9;
  endtask

  // One clock of stimulus, model update, then compare the main DUT after the edge.
  task automatic step(input logic [8:0] r, input logic [8:0] e, input logic a);
    logic [8:0] clr;
    Req = r; Enable = e; Ack = a;
    clr = '0;
    if (m_grant != 0) begin
      if (a) begin
        clr[m_grant-1] = 1'b1;
        m_last  = m_grant;
        m_grant = 0;
        m_gap   = 1'b1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else begin
      m_grant = pick(m_pend & e, m_last);
    end
    m_pend = (m_pend & ~clr) | (r & ~m_prev);
    m_prev = r;
    @(posedge Clock); #1;
    check("pending", Pending, m_pend);
    check("grant_valid", Grant_Valid, (m_grant != 0));
    check("grant_id", Grant_Id, m_grant);
    check("irq", Irq, |(m_pend & e));
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    model_reset();
    @(posedge Clock); #1;
    check("rst_pending", Pending, 9'h000);
    check("rst_valid", Grant_Valid, 1'b0);
    check("rst_id", Grant_Id, 4'd0);
    check("rst_irq", Irq, 1'b0);
    Reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    Req = '0; Enable = 9'h1ff; Ack = 1'b0; Ack_b = 1'b0;
    Req_b = 9'h001;  // channel 1 line high (inverted to inactive) through reset
    do_reset();

    // Inverted channel 1: held high through reset, no grant; falling edge latches it.
    step(9'h000, 9'h1ff, 1'b0);
    step(9'h000, 9'h1ff, 1'b0);
    check("bub_no_pend", Pending_b, 9'h000);
    check("bub_no_grant", Grant_Valid_b, 1'b0);
    Req_b = 9'h000;
    step(9'h000, 9'h1ff, 1'b0);
    check("bub_pend", Pending_b, 9'h001);
    step(9'h000, 9'h1ff, 1'b0);
    check("bub_grant_id", Grant_Id_b, 4'd1);
    check("bub_grant_valid", Grant_Valid_b, 1'b1);
    Ack_b = 1'b1;
    step(9'h000, 9'h1ff, 1'b0);
    Ack_b = 1'b0;
    check("bub_cleared", Grant_Id_b, 4'd0);

    // Single pulse on channel 3: grant two cycles later, Ack clears.
    step(9'h004, 9'h1ff, 1'b0);
    step(9'h000, 9'h1ff, 1'b0);
    check("ch3_id", Grant_Id, 4'd3);
    check("ch3_valid", Grant_Valid, 1'b1);
    step(9'h000, 9'h1ff, 1'b1);
    check("ch3_pend_clr", Pending, 9'h000);
    check("ch3_id_clr", Grant_Id, 4'd0);
    step(9'h000, 9'h1ff, 1'b1);  // Ack during gap is ignored
    step(9'h000, 9'h1ff, 1'b0);

    // Channels 1 and 5 together; channel 1 re-pulsed during grant 5.
    step(9'h011, 9'h1ff, 1'b0);
    step(9'h000, 9'h1ff, 1'b0);
    check("pair_first", Grant_Id, 4'd1);
    step(9'h000, 9'h1ff, 1'b1);
    step(9'h000, 9'h1ff, 1'b0);
    step(9'h000, 9'h1ff, 1'b0);
    check("pair_second", Grant_Id, 4'd5);
    step(9'h001, 9'h1ff, 1'b0);
    step(9'h000, 9'h1ff, 1'b1);
    step(9'h000, 9'h1ff, 1'b0);
    step(9'h000, 9'h1ff, 1'b0);
    check("pair_third", Grant_Id, 4'd1);
    step(9'h000, 9'h1ff, 1'b1);
    step(9'h000, 9'h1ff, 1'b0);

    // Disabled channel 4 latches without Irq or grant until enabled.
    step(9'h008, 9'h1f7, 1'b0);
    step(9'h000, 9'h1f7, 1'b0);
    step(9'h000, 9'h1f7, 1'b0);
    check("dis_pend", Pending[3], 1'b1);
    check("dis_irq", Irq, 1'b0);
    check("dis_no_grant", Grant_Valid, 1'b0);
    step(9'h000, 9'h1ff, 1'b0);
    check("en_grant", Grant_Id, 4'd4);
    step(9'h000, 9'h1ff, 1'b1);
    step(9'h000, 9'h1ff, 1'b0);

    // Channel 7 re-rises on its own Ack cycle: set wins, grant 7 reissued.
    step(9'h040, 9'h1ff, 1'b0);
    step(9'h000, 9'h1ff, 1'b0);
    check("c7_first", Grant_Id, 4'd7);
    step(9'h040, 9'h1ff, 1'b1);
    check("c7_set_wins", Pending[6], 1'b1);
    check("c7_dropped", Grant_Valid, 1'b0);
    step(9'h000, 9'h1ff, 1'b0);
    check("c7_gap", Grant_Valid, 1'b0);
    step(9'h000, 9'h1ff, 1'b0);
    check("c7_reissue", Grant_Id, 4'd7);

    // Asynchronous reset mid-grant with another channel still pending.
    step(9'h000, 9'h1ff, 1'b1);
    step(9'h000, 9'h1ff, 1'b0);
    step(9'h014, 9'h1ff, 1'b0);
    step(9'h000, 9'h1ff, 1'b0);
    check("pre_rst_id", Grant_Id, 4'd3);
    #2 Reset_n = 1'b0;
    #1;
    check("arst_valid", Grant_Valid, 1'b0);
    check("arst_id", Grant_Id, 4'd0);
    check("arst_pending", Pending, 9'h000);
    check("arst_irq", Irq, 1'b0);
    model_reset();
    @(posedge Clock); #1;
    Reset_n = 1'b1;
    step(9'h000, 9'h1ff, 1'b0);
    step(9'h000, 9'h1ff, 1'b0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [8:0] r, e;
      r = 9'($urandom & $urandom);
      e = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'h1ff;
      step(r, e, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
